account_perf_ranker: RTL and testbench

//   Consumer end of the account/performance input stream, single clock.

---
 rtl/account_perf_ranker_if.sv | 23 ++
 rtl/account_perf_ranker.sv | 121 ++++++++++++
 tb/tb_account_perf_ranker.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/account_perf_ranker_if.sv
// Record stream into the ranker and its ranked-account result.
// The master drives records; the slave (ranker) returns ready and the result pulse.
interface account_perf_ranker_if #(
  parameter int DSIZE = 8
);
  logic             in_valid;
  logic [DSIZE-1:0] in_account;
  logic [DSIZE-1:0] in_A;
  logic [DSIZE-1:0] in_T;
  logic             ready;
  logic             out_valid;
  logic [DSIZE-1:0] out_account;

  modport master (
    output in_valid, in_account, in_A, in_T,
    input  ready, out_valid, out_account
  );

  modport slave (
    input  in_valid, in_account, in_A, in_T,
    output ready, out_valid, out_account
  );
endinterface

// File: rtl/account_perf_ranker.sv
// Ranks accounts by A*T over a sliding window of WIN records and reports the
// lowest-performing account; 10 cycles per record, ready is low while busy.
module account_perf_ranker #(
  parameter int DSIZE = 8,
  parameter int WIN   = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  account_perf_ranker_if.slave s_rec
);
  localparam int PW = 2 * DSIZE;
  localparam int BW = $clog2(DSIZE);
  localparam int CW = $clog2(WIN + 1);

  typedef enum logic [1:0] {IDLE, MUL, CMP} state_t;

  state_t           r_state;
  logic             r_ready;
  logic             r_out_valid;
  logic [DSIZE-1:0] r_out_account;
  logic [DSIZE-1:0] r_a;
  logic [DSIZE-1:0] r_t;
  logic [DSIZE-1:0] r_in_acct;
  logic [PW-1:0]    r_acc;
  logic [BW-1:0]    r_bit;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    r_win_perf [WIN];
  logic [DSIZE-1:0] r_win_acct [WIN];

  logic [PW-1:0]    w_a_shift;
  logic [PW-1:0]    w_perf_n [WIN];
  logic [DSIZE-1:0] w_acct_n [WIN];
  logic [PW-1:0]    w_min_perf;
  logic [DSIZE-1:0] w_min_acct;
  logic [CW-1:0]    w_count_n;

  assign w_a_shift = PW'(r_a) << r_bit;
  assign w_count_n = (r_count == CW'(WIN)) ? r_count : r_count + CW'(1);

  // Window after the shift: index 0 is oldest, WIN-1 is the record just multiplied.
  // The <= scan lets the newest of equal minima win.
  always_comb begin
    for (int i = 0; i < WIN - 1; i++) begin
      w_perf_n[i] = r_win_perf[i+1];
      w_acct_n[i] = r_win_acct[i+1];
    end
    w_perf_n[WIN-1] = r_acc;
    w_acct_n[WIN-1] = r_in_acct;
    w_min_perf = w_perf_n[0];
    w_min_acct = w_acct_n[0];
    for (int i = 1; i < WIN; i++) begin
      if (w_perf_n[i] <= w_min_perf) begin
        w_min_perf = w_perf_n[i];
        w_min_acct = w_acct_n[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ready       <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_account <= '0;
      r_a           <= '0;
      r_t           <= '0;
      r_in_acct     <= '0;
      r_acc         <= '0;
      r_bit         <= '0;
      r_count       <= '0;
      for (int i = 0; i < WIN; i++) begin
        r_win_perf[i] <= '1;
        r_win_acct[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_out_valid <= 1'b0;
          if (s_rec.in_valid && r_ready) begin
            r_a       <= s_rec.in_A;
            r_t       <= s_rec.in_T;
            r_in_acct <= s_rec.in_account;
            r_acc     <= '0;
            r_bit     <= '0;
            r_ready   <= 1'b0;
            r_state   <= MUL;
          end else begin
            r_ready <= 1'b1;
          end
        end
        MUL: begin
          if (r_t[r_bit]) begin
            r_acc <= r_acc + w_a_shift;
          end
          r_bit <= r_bit + BW'(1);
          if (r_bit == BW'(DSIZE - 1)) begin
            r_state <= CMP;
          end
        end
        CMP: begin
          for (int i = 0; i < WIN; i++) begin
            r_win_perf[i] <= w_perf_n[i];
            r_win_acct[i] <= w_acct_n[i];
          end
          r_count <= w_count_n;
          if (w_count_n == CW'(WIN)) begin
            r_out_valid   <= 1'b1;
            r_out_account <= w_min_acct;
          end
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_rec.ready       = r_ready;
  assign s_rec.out_valid   = r_out_valid;
  assign s_rec.out_account = r_out_account;
endmodule

// File: tb/tb_account_perf_ranker.sv
// Directed stimulus with a queue-based scoreboard for account_perf_ranker.
module tb_account_perf_ranker;
  localparam int DSIZE = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [DSIZE-1:0] exp_q [$];

  account_perf_ranker_if #(.DSIZE(DSIZE)) ifc ();

  account_perf_ranker #(.DSIZE(DSIZE), .WIN(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_rec (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ifc.out_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_out: got account %0d with no result expected", ifc.out_account);
      end else begin
        logic [DSIZE-1:0] e;
        e = exp_q.pop_front();
        if (ifc.out_account !== e) begin
          n_fail++;
          $display("FAIL out_account: got %0d expected %0d", ifc.out_account, e);
        end
      end
      n_checks++;
      if (ifc.ready !== 1'b1) begin
        n_fail++;
        $display("FAIL ready_with_out: got %0b expected 1", ifc.ready);
      end
    end
  end

  // Wait for ready, present one record for one accept edge; push expectation if any.
  task automatic send(input int acct, input int a, input int t, input bit has_out, input int exp_acct);
    int budget;
    budget = 0;
    @(negedge clk);
    while (ifc.ready !== 1'b1 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=%0b expected 1 within 100 cycles", ifc.ready);
    end else begin
      ifc.in_valid   = 1'b1;
      ifc.in_account = DSIZE'(acct);
      ifc.in_A       = DSIZE'(a);
      ifc.in_T       = DSIZE'(t);
      if (has_out) exp_q.push_back(DSIZE'(exp_acct));
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", int'(ifc.ready), 0);
    chk("reset_out_valid", int'(ifc.out_valid), 0);
    chk("reset_out_account", int'(ifc.out_account), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_release", int'(ifc.ready), 1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    repeat (15) @(negedge clk);
    chk("pending_results", exp_q.size(), 0);
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    ifc.in_valid   = 1'b0;
    ifc.in_account = '0;
    ifc.in_A       = '0;
    ifc.in_T       = '0;

    do_reset(2);

    // Window fill: perf 100,50,200,50,300 -> tie on 50, newest (13) wins.
    send(10, 10, 10, 0, 0);
    send(11,  5, 10, 0, 0);
    send(12, 20, 10, 0, 0);
    send(13, 10,  5, 0, 0);
    send(14, 30, 10, 1, 13);

    // Slide the window.
    send(15,   1,   1, 1, 15);
    send(16, 255, 255, 1, 15);

    // Back-pressure: junk record held during the multiply must be dropped.
    send(20, 2, 2, 1, 15);
    @(negedge clk);
    chk("busy_ready", int'(ifc.ready), 0);
    ifc.in_valid   = 1'b1;
    ifc.in_account = 8'd99;
    ifc.in_A       = 8'd1;
    ifc.in_T       = 8'd1;
    repeat (4) @(negedge clk);
    ifc.in_valid = 1'b0;
    send(21, 1, 1, 1, 21);

    // Extremes: 65025 entries push out the small ones; all-equal -> newest.
    send(1, 255, 255, 1, 21);
    send(2, 255, 255, 1, 21);
    send(3, 255, 255, 1, 21);
    send(4, 255, 255, 1, 21);
    send(5, 255, 255, 1, 5);
    for (int k = 31; k <= 35; k++) send(k, 1, 1, 1, k);
    drain();

    // Reset during a multiply clears the window and drops the record in flight.
    do_reset(2);
    send(41, 1, 1, 0, 0);
    send(42, 1, 1, 0, 0);
    send(43, 1, 1, 0, 0);
    send(44, 1, 1, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midreset_ready", int'(ifc.ready), 0);
    chk("midreset_out_valid", int'(ifc.out_valid), 0);
    rst_n = 1'b1;
    // perf 9,4,5,16,7 -> account 52.
    send(51, 3, 3, 0, 0);
    send(52, 2, 2, 0, 0);
    send(53, 5, 1, 0, 0);
    send(54, 4, 4, 0, 0);
    send(55, 7, 1, 1, 52);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
